spi_loopback_top: RTL and testbench

- Self-contained bi-directional SPI round-trip block.
- An internal SPI master (side A) serially sends a 32-bit word to an internal SPI slave (side B).
- B captures the word, forms a response equal to the word plus one, and A clocks that response back.
- Used as a loopback/bring-up block for the SPI master/slave pair; all SPI wires (sclk, cs_n, mosi, miso) are internal.

---
 rtl/spi_loopback_top.sv | 242 ++++++++++++++++++++++++
 tb/tb_spi_loopback_top.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/spi_loopback_top.sv
// -----------------------------------------------------------------------------
// spi_loopback_top
//   SPI mode-0 round trip between an internal master (side A) and an internal
//   slave (side B). After reset is released, A sends one DATA_W-bit word MSB
//   first. B captures it, computes word+1 and returns that value to A. One round
//   trip runs per reset release. sclk, cs_n, mosi and miso exist only inside
//   this block.
//
// Ports
//   clk            : system clock, rising edge
//   rst_n          : synchronous reset, ACTIVE HIGH (1 = reset)
//   in_data_A      : word A sends, latched on the first clock edge after release
//   out_data_B     : word received by B (valid while done_A_to_B = 1)
//   out_data_A     : response received by A (valid while done_B_to_A = 1)
//   done_A_to_B    : sticky, B has received all DATA_W bits
//   response_ready : sticky, B has loaded its response for transmission
//   done_B_to_A    : sticky, A has received the full response
// -----------------------------------------------------------------------------
module spi_loopback_top #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data_A,
    output logic [DATA_W-1:0] out_data_B,
    output logic [DATA_W-1:0] out_data_A,
    output logic              done_A_to_B,
    output logic              response_ready,
    output logic              done_B_to_A
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 32'sd1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 32'sd1);

    // Response rule: the received word plus one, wrapping at 2^DATA_W.
    function automatic logic [DATA_W-1:0] word_inc(input logic [DATA_W-1:0] w);
        return w + DATA_W'(1'b1);
    endfunction

    typedef enum logic [2:0] {M_IDLE, M_LOAD, M_TX, M_GAP, M_RX, M_DONE} m_state_t;
    typedef enum logic [2:0] {S_IDLE, S_RX, S_CALC, S_TX, S_HOLD} s_state_t;

    // Internal SPI wires. The master drives sclk_r, cs_n_r and mosi_r; the slave drives miso_r.
    logic sclk_r;
    logic cs_n_r;
    logic mosi_r;
    logic miso_r;

    // Master state
    m_state_t          m_state_r;
    logic [DATA_W-1:0] m_shift_r;
    logic [DIV_W-1:0]  m_div_r;
    logic [BIT_W-1:0]  m_bit_r;
    logic              m_gap_cnt_r;
    logic [DATA_W-1:0] out_data_a_r;
    logic              done_b_to_a_r;
    logic              m_tick_s;

    // Slave state
    s_state_t          s_state_r;
    logic [DATA_W-1:0] s_shift_r;
    logic [BIT_W-1:0]  s_bit_r;
    logic              s_armed_r;
    logic              sclk_d_r;
    logic [DATA_W-1:0] out_data_b_r;
    logic              done_a_to_b_r;
    logic              response_ready_r;
    logic [DATA_W-1:0] resp_s;
    logic              sclk_rise_s;
    logic              sclk_fall_s;

    assign m_tick_s    = (m_div_r == DIV_LAST);
    assign sclk_rise_s = sclk_r & ~sclk_d_r;
    assign sclk_fall_s = ~sclk_r & sclk_d_r;
    assign resp_s      = word_inc(out_data_b_r);

    // Master FSM: loads the word, shifts it out, waits for the response, then clocks the response in.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            m_state_r     <= M_IDLE;
            m_shift_r     <= {DATA_W{1'b0}};
            m_div_r       <= {DIV_W{1'b0}};
            m_bit_r       <= {BIT_W{1'b0}};
            m_gap_cnt_r   <= 1'b0;
            sclk_r        <= 1'b0;
            cs_n_r        <= 1'b1;
            mosi_r        <= 1'b0;
            out_data_a_r  <= {DATA_W{1'b0}};
            done_b_to_a_r <= 1'b0;
        end else begin
            case (m_state_r)
                M_IDLE: begin
                    m_shift_r <= in_data_A;
                    m_state_r <= M_LOAD;
                end
                M_LOAD: begin
                    cs_n_r    <= 1'b0;
                    mosi_r    <= m_shift_r[DATA_W-1];
                    m_div_r   <= {DIV_W{1'b0}};
                    m_bit_r   <= {BIT_W{1'b0}};
                    m_state_r <= M_TX;
                end
                M_TX: begin
                    if (m_tick_s) begin
                        m_div_r <= {DIV_W{1'b0}};
                        sclk_r  <= ~sclk_r;
                        // The falling edge presents the next bit. The slave samples on the rise.
                        if (sclk_r) begin
                            m_shift_r <= {m_shift_r[DATA_W-2:0], 1'b0};
                            mosi_r    <= m_shift_r[DATA_W-2];
                            if (m_bit_r == BIT_LAST) begin
                                m_bit_r     <= {BIT_W{1'b0}};
                                m_gap_cnt_r <= 1'b0;
                                m_state_r   <= M_GAP;
                            end else begin
                                m_bit_r <= m_bit_r + BIT_W'(1'b1);
                            end
                        end
                    end else begin
                        m_div_r <= m_div_r + DIV_W'(1'b1);
                    end
                end
                M_GAP: begin
                    // After response_ready rises, wait two more cycles so that miso is settled.
                    if (response_ready_r) begin
                        if (m_gap_cnt_r) begin
                            m_div_r   <= {DIV_W{1'b0}};
                            m_bit_r   <= {BIT_W{1'b0}};
                            m_state_r <= M_RX;
                        end else begin
                            m_gap_cnt_r <= 1'b1;
                        end
                    end
                end
                M_RX: begin
                    if (m_tick_s) begin
                        m_div_r <= {DIV_W{1'b0}};
                        sclk_r  <= ~sclk_r;
                        // Capture miso at the end of the high phase. The slave changes miso
                        // only after it sees the fall, so the bit is stable for the whole high phase.
                        if (sclk_r) begin
                            m_shift_r <= {m_shift_r[DATA_W-2:0], miso_r};
                            if (m_bit_r == BIT_LAST) begin
                                out_data_a_r  <= {m_shift_r[DATA_W-2:0], miso_r};
                                done_b_to_a_r <= 1'b1;
                                cs_n_r        <= 1'b1;
                                m_state_r     <= M_DONE;
                            end else begin
                                m_bit_r <= m_bit_r + BIT_W'(1'b1);
                            end
                        end
                    end else begin
                        m_div_r <= m_div_r + DIV_W'(1'b1);
                    end
                end
                M_DONE: begin
                    m_state_r <= M_DONE;
                end
                default: begin
                    m_state_r <= M_IDLE;
                end
            endcase
        end
    end

    // Slave FSM: detects sclk edges with a one-cycle delayed copy, receives the word, then returns word+1.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            s_state_r        <= S_IDLE;
            s_shift_r        <= {DATA_W{1'b0}};
            s_bit_r          <= {BIT_W{1'b0}};
            s_armed_r        <= 1'b0;
            sclk_d_r         <= 1'b0;
            miso_r           <= 1'b0;
            out_data_b_r     <= {DATA_W{1'b0}};
            done_a_to_b_r    <= 1'b0;
            response_ready_r <= 1'b0;
        end else begin
            sclk_d_r <= sclk_r;
            case (s_state_r)
                S_IDLE: begin
                    if (!cs_n_r) begin
                        s_bit_r   <= {BIT_W{1'b0}};
                        s_state_r <= S_RX;
                    end
                end
                S_RX: begin
                    if (sclk_rise_s && !cs_n_r) begin
                        s_shift_r <= {s_shift_r[DATA_W-2:0], mosi_r};
                        if (s_bit_r == BIT_LAST) begin
                            out_data_b_r  <= {s_shift_r[DATA_W-2:0], mosi_r};
                            done_a_to_b_r <= 1'b1;
                            s_state_r     <= S_CALC;
                        end else begin
                            s_bit_r <= s_bit_r + BIT_W'(1'b1);
                        end
                    end
                end
                S_CALC: begin
                    s_shift_r        <= resp_s;
                    miso_r           <= resp_s[DATA_W-1];
                    response_ready_r <= 1'b1;
                    s_bit_r          <= {BIT_W{1'b0}};
                    s_armed_r        <= 1'b0;
                    s_state_r        <= S_TX;
                end
                S_TX: begin
                    // Ignore the trailing fall left over from the master's transmit phase.
                    // Start counting falls only after the first rise of the response phase.
                    if (sclk_rise_s) begin
                        s_armed_r <= 1'b1;
                    end
                    if (sclk_fall_s && s_armed_r) begin
                        if (s_bit_r == BIT_LAST) begin
                            s_state_r <= S_HOLD;
                        end else begin
                            s_shift_r <= {s_shift_r[DATA_W-2:0], 1'b0};
                            miso_r    <= s_shift_r[DATA_W-2];
                            s_bit_r   <= s_bit_r + BIT_W'(1'b1);
                        end
                    end
                end
                S_HOLD: begin
                    s_state_r <= S_HOLD;
                end
                default: begin
                    s_state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign out_data_A     = out_data_a_r;
    assign out_data_B     = out_data_b_r;
    assign done_A_to_B    = done_a_to_b_r;
    assign response_ready = response_ready_r;
    assign done_B_to_A    = done_b_to_a_r;

endmodule

// File: tb/tb_spi_loopback_top.sv
// -----------------------------------------------------------------------------
// tb_spi_loopback_top
//   Bench for spi_loopback_top. It drives a default build (CLK_DIV=4) and a
//   CLK_DIV=1 build. When a round trip is started, the expected words are
//   pushed to scoreboard queues. Each expected word is popped and compared
//   when the matching done flag rises.
// -----------------------------------------------------------------------------
module tb_spi_loopback_top;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic [31:0] din0, din1;
    logic [31:0] ob0, oa0, ob1, oa1;
    logic        dab0, rr0, dba0, dab1, rr1, dba1;

    spi_loopback_top #(.DATA_W(32), .CLK_DIV(4)) dut0 (
        .clk(clk), .rst_n(rst0), .in_data_A(din0),
        .out_data_B(ob0), .out_data_A(oa0),
        .done_A_to_B(dab0), .response_ready(rr0), .done_B_to_A(dba0)
    );

    spi_loopback_top #(.DATA_W(32), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst1), .in_data_A(din1),
        .out_data_B(ob1), .out_data_A(oa1),
        .done_A_to_B(dab1), .response_ready(rr1), .done_B_to_A(dba1)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cur_sel  = 0;
    logic [31:0] exp_b_q[$];
    logic [31:0] exp_a_q[$];

    logic [31:0] v_ob, v_oa;
    logic        v_dab, v_rr, v_dba;

    // View of whichever DUT is under test
    always_comb begin
        if (cur_sel == 0) begin
            v_ob = ob0; v_oa = oa0; v_dab = dab0; v_rr = rr0; v_dba = dba0;
        end else begin
            v_ob = ob1; v_oa = oa1; v_dab = dab1; v_rr = rr1; v_dba = dba1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_rst(input int sel, input logic v);
        if (sel == 0) rst0 = v; else rst1 = v;
    endtask

    task automatic set_din(input int sel, input logic [31:0] d);
        if (sel == 0) din0 = d; else din1 = d;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_out_a"}, v_oa, 32'h0000_0000);
        check_eq({tag, "_out_b"}, v_ob, 32'h0000_0000);
        check_eq({tag, "_flags"}, {29'd0, v_dab, v_rr, v_dba}, 32'h0000_0000);
    endtask

    task automatic hold_reset(input int sel, input int cycles, input string tag);
        cur_sel = sel;
        @(negedge clk);
        set_rst(sel, 1'b1);
        repeat (cycles) @(negedge clk);
        check_zero(tag);
    endtask

    // Release reset with word d loaded and follow the round trip to done_B_to_A.
    task automatic run_trip(input int sel, input logic [31:0] d, input int lat_max, input string tag);
        bit seen_b, seen_r, seen_a;
        int lat;
        cur_sel = sel;
        set_din(sel, d);
        exp_b_q.push_back(d);
        exp_a_q.push_back(d + 32'd1);
        seen_b = 1'b0; seen_r = 1'b0; seen_a = 1'b0;
        @(negedge clk);
        set_rst(sel, 1'b0);
        // Check n is taken after the posedge at offset n-1 from the latch edge.
        for (int cyc = 1; cyc <= lat_max + 20 && !seen_a; cyc++) begin
            @(negedge clk);
            lat = cyc - 1;
            if (v_dab && !seen_b) begin
                seen_b = 1'b1;
                check_eq({tag, "_order_ab"}, {30'd0, v_rr, v_dba}, 32'd0);
                if (exp_b_q.size() > 0) check_eq({tag, "_out_b"}, v_ob, exp_b_q.pop_front());
                else check_eq({tag, "_sb_b_empty"}, 32'd0, 32'd1);
            end
            if (v_rr && !seen_r) begin
                seen_r = 1'b1;
                check_eq({tag, "_order_rr"}, {30'd0, seen_b, v_dba}, 32'd2);
            end
            if (v_dba && !seen_a) begin
                seen_a = 1'b1;
                check_eq({tag, "_order_ba"}, {30'd0, v_dab, v_rr}, 32'd3);
                check_eq({tag, "_latency_ok"}, {31'd0, lat <= lat_max}, 32'd1);
                if (exp_a_q.size() > 0) check_eq({tag, "_out_a"}, v_oa, exp_a_q.pop_front());
                else check_eq({tag, "_sb_a_empty"}, 32'd0, 32'd1);
            end
        end
        if (!seen_a) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
            exp_b_q.delete();
            exp_a_q.delete();
        end
    endtask

    // Main sequence
    initial begin
        int bad;
        rst0 = 1'b1; rst1 = 1'b1;
        din0 = 32'h0000_0000; din1 = 32'h0000_0000;

        hold_reset(0, 5, "rst_a");
        run_trip(0, 32'h3F81_A2C4, 528, "t1");

        // After done, a new in_data_A must not start another transfer
        set_din(0, 32'h1234_5678);
        bad = 0;
        repeat (600) begin
            @(negedge clk);
            if (v_oa !== 32'h3F81_A2C5 || v_ob !== 32'h3F81_A2C4 || {v_dab, v_rr, v_dba} !== 3'b111)
                bad++;
        end
        check_eq("hold_bad_cycles", bad, 32'd0);
        check_eq("hold_out_a", v_oa, 32'h3F81_A2C5);

        hold_reset(0, 3, "rst_b");
        run_trip(0, 32'hFFFF_FFFF, 528, "wrap");

        hold_reset(0, 3, "rst_c");
        run_trip(0, 32'h8000_0001, 528, "order");

        // Reset midway through the transmit phase
        hold_reset(0, 3, "rst_d");
        set_din(0, 32'hA5C3_0F96);
        @(negedge clk);
        rst0 = 1'b0;
        repeat (100) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        check_zero("abort_tx");

        // Reset again after B has captured its word
        rst0 = 1'b0;
        for (int i = 0; i < 400 && !v_dab; i++) @(negedge clk);
        check_eq("abort2_dab", {31'd0, v_dab}, 32'd1);
        check_eq("abort2_out_b", v_ob, 32'hA5C3_0F96);
        rst0 = 1'b1;
        @(negedge clk);
        check_zero("abort_rx");
        run_trip(0, 32'h0000_0010, 528, "after_abort");

        // Fast build
        hold_reset(1, 5, "rst_fast");
        run_trip(1, 32'h42C8_0000, 144, "fast");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
